div_unit: RTL and testbench

Multi-cycle 32-bit integer divider for the execute stage of the five-stage MIPS pipeline. It serves DIV/DIVU and produces the 64-bit {HI, LO} pair that travels down the pipeline to the HI/LO write-back. While a division is in flight it raises a stall request. The hazard unit turns that request into stallE/stallM/stallW and flushes for the pipeline control registers.

---
 rtl/div_unit.sv | 145 ++++++++++++++
 tb/tb_div_unit.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// div_unit: multi-cycle 32-bit restoring divider for DIV/DIVU in the E stage.
// It produces {remainder, quotient} as {HI, LO} and requests a stall while a
// division is in flight.
// Optional feature macro: DIV_ZERO_FAST_EN. When it is defined, a zero divisor
// takes a two-cycle BYZERO path that returns 64'h0.
module div_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        signed_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o,
  output logic        stall_o
);

  typedef enum logic [1:0] {
    FREE   = 2'd0,
`ifdef DIV_ZERO_FAST_EN
    BYZERO = 2'd1,
`endif
    ON     = 2'd2,
    END    = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [63:0] result_q, result_d;
  logic [64:0] work_q;
  logic [31:0] divisor_q;
  logic        neg_a_q, neg_b_q;
  logic        load;
  logic [64:0] step_w;

  // Magnitude of an operand; negation applies only to signed operations.
  function automatic logic [31:0] abs32(input logic signed [31:0] v, input logic en);
    logic signed [31:0] r;
    r = v;
    if (en && v[31]) r = -v;
    return r;
  endfunction

  // One restoring step. The upper 33 bits hold the partial remainder. The
  // lower 32 bits shift out dividend bits and shift in quotient bits.
  function automatic logic [64:0] div_step(input logic [64:0] w, input logic [31:0] d);
    logic [64:0] sh;
    logic [32:0] trial;
    sh    = {w[63:0], 1'b0};
    trial = sh[64:32] - {1'b0, d};
    if (sh[64:32] >= {1'b0, d}) return {trial, sh[31:1], 1'b1};
    return sh;
  endfunction

  // Sign correction. The quotient is negated when the operand signs differ.
  // The remainder follows the dividend. 0x80000000 / -1 wraps to 0x80000000.
  function automatic logic [63:0] sign_fix(input logic [63:0] w, input logic neg_a,
                                           input logic neg_b);
    logic signed [31:0] q, r;
    q = w[31:0];
    r = w[63:32];
    if (neg_a ^ neg_b) q = -q;
    if (neg_a) r = -r;
    return {r, q};
  endfunction

  assign load     = (state_q == FREE) && start_i && !annul_i;
  assign step_w   = div_step(work_q, divisor_q);
  assign result_o = result_q;
  assign ready_o  = (state_q == END);
  assign stall_o  = start_i && !annul_i && !rst && (state_q != END);

  // Control state, counter and architectural result; these are cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= FREE;
      cnt_q    <= 6'd0;
      result_q <= 64'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  // Working datapath: load operand magnitudes on acceptance, then iterate in ON.
  always_ff @(posedge clk) begin
    if (load) begin
      work_q    <= {33'd0, abs32(opdata1_i, signed_i)};
      divisor_q <= abs32(opdata2_i, signed_i);
      neg_a_q   <= signed_i & opdata1_i[31];
      neg_b_q   <= signed_i & opdata2_i[31];
    end else if (state_q == ON) begin
      work_q    <= step_w;
    end
  end

  // Next-state logic. The result is written on the edge into END, so the new
  // value appears in the same cycle as the ready pulse.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    case (state_q)
      FREE: begin
        if (start_i && !annul_i) begin
          cnt_d   = 6'd0;
          state_d = ON;
`ifdef DIV_ZERO_FAST_EN
          if (opdata2_i == 32'd0) state_d = BYZERO;
`endif
        end
      end
      ON: begin
        if (annul_i) begin
          state_d = FREE;
          cnt_d   = 6'd0;
        end else begin
          cnt_d = cnt_q + 6'd1;
          if (cnt_q == 6'd31) begin
            state_d  = END;
            result_d = sign_fix(step_w[63:0], neg_a_q, neg_b_q);
          end
        end
      end
`ifdef DIV_ZERO_FAST_EN
      BYZERO: begin
        if (annul_i) begin
          state_d = FREE;
        end else begin
          state_d  = END;
          result_d = 64'd0;
        end
      end
`endif
      END: begin
        state_d = FREE;
        cnt_d   = 6'd0;
      end
      default: state_d = FREE;
    endcase
  end

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed, table-driven bench for div_unit.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic        signed_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;
  logic        stall_o;

  int total  = 0;
  int passed = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sgn;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs[12];

  div_unit dut (
    .clk(clk), .rst(rst), .start_i(start_i), .signed_i(signed_i),
    .opdata1_i(opdata1_i), .opdata2_i(opdata2_i), .annul_i(annul_i),
    .result_o(result_o), .ready_o(ready_o), .stall_o(stall_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Starts a division in the current cycle T (the caller is aligned just after
  // a rising edge). It expects ready at T+lat and then drops start at T+lat+1.
  task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                         input logic [63:0] exp, input int lat, input logic chk_res,
                         input string name);
    logic [63:0] held;
    start_i = 1'b1; signed_i = sgn; opdata1_i = a; opdata2_i = b;
    for (int c = 0; c < lat; c++) begin
      @(negedge clk);
      chk({name, " stall busy"}, 64'(stall_o), 64'd1);
      chk({name, " ready early"}, 64'(ready_o), 64'd0);
      next_cycle();
    end
    @(negedge clk);
    chk({name, " ready"}, 64'(ready_o), 64'd1);
    chk({name, " stall end"}, 64'(stall_o), 64'd0);
    if (chk_res) chk({name, " result"}, result_o, exp);
    held = result_o;
    next_cycle();
    start_i = 1'b0;
    @(negedge clk);
    chk({name, " ready after"}, 64'(ready_o), 64'd0);
    chk({name, " result held"}, result_o, held);
    next_cycle();
  endtask

  // Counts ready pulses over n cycles with start low; none are expected.
  task automatic quiet(input int n, input string name);
    int pulses;
    pulses = 0;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      if (ready_o) pulses++;
      next_cycle();
    end
    chk({name, " no ready"}, 64'(pulses), 64'd0);
  endtask

  initial begin
    vecs[0]  = '{32'd100,       32'd7,         1'b0, {32'd2,         32'd14}};
    vecs[1]  = '{32'hFFFFFFF9,  32'h00000002,  1'b1, {32'hFFFFFFFF,  32'hFFFFFFFD}};
    vecs[2]  = '{32'h80000000,  32'hFFFFFFFF,  1'b1, {32'h00000000,  32'h80000000}};
    vecs[3]  = '{32'd9,         32'd3,         1'b0, {32'd0,         32'd3}};
    vecs[4]  = '{32'd10,        32'd4,         1'b0, {32'd2,         32'd2}};
    vecs[5]  = '{32'hFFFFFFFF,  32'd1,         1'b0, {32'd0,         32'hFFFFFFFF}};
    vecs[6]  = '{32'd7,         32'hFFFFFFFE,  1'b1, {32'd1,         32'hFFFFFFFD}};
    vecs[7]  = '{32'hFFFFFFF9,  32'hFFFFFFFE,  1'b1, {32'hFFFFFFFF,  32'd3}};
    vecs[8]  = '{32'h80000000,  32'hFFFFFFFF,  1'b0, {32'h80000000,  32'd0}};
    vecs[9]  = '{32'd5,         32'd7,         1'b0, {32'd5,         32'd0}};
    vecs[10] = '{32'hFFFFFF9C,  32'd7,         1'b1, {32'hFFFFFFFE,  32'hFFFFFFF2}};
    vecs[11] = '{32'hDEADBEEF,  32'h10,        1'b0, {32'h0000000F,  32'h0DEADBEE}};

    rst = 1'b1; start_i = 1'b1; signed_i = 1'b0; annul_i = 1'b0;
    opdata1_i = 32'd1; opdata2_i = 32'd1;
    @(negedge clk);
    chk("stall in reset", 64'(stall_o), 64'd0);
    next_cycle();
    next_cycle();
    rst = 1'b0; start_i = 1'b0;
    @(negedge clk);
    chk("reset result", result_o, 64'd0);
    chk("reset ready", 64'(ready_o), 64'd0);
    chk("reset stall", 64'(stall_o), 64'd0);
    next_cycle();

    for (int i = 0; i < 12; i++)
      run_div(vecs[i].a, vecs[i].b, vecs[i].sgn, vecs[i].exp, 33, 1'b1, $sformatf("vec%0d", i));

    // Annul mid-flight after a known prior result.
    run_div(32'd11, 32'd3, 1'b0, 64'h0000000200000003, 33, 1'b1, "pre-annul");
    start_i = 1'b1; signed_i = 1'b0; opdata1_i = 32'd100; opdata2_i = 32'd7;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("annul stall busy", 64'(stall_o), 64'd1);
      next_cycle();
    end
    annul_i = 1'b1;
    @(negedge clk);
    chk("annul stall", 64'(stall_o), 64'd0);
    next_cycle();
    annul_i = 1'b0; start_i = 1'b0;
    @(negedge clk);
    chk("annul stall free", 64'(stall_o), 64'd0);
    chk("annul result kept", result_o, 64'h0000000200000003);
    next_cycle();
    quiet(40, "annul");
    chk("annul result final", result_o, 64'h0000000200000003);

    // Back-to-back DIVU 9/3 then 10/4 with start held high.
    start_i = 1'b1; signed_i = 1'b0; opdata1_i = 32'd9; opdata2_i = 32'd3;
    for (int c = 0; c < 33; c++) next_cycle();
    @(negedge clk);
    chk("b2b first ready", 64'(ready_o), 64'd1);
    chk("b2b first result", result_o, {32'd0, 32'd3});
    next_cycle();
    opdata1_i = 32'd10; opdata2_i = 32'd4;
    @(negedge clk);
    chk("b2b second accept stall", 64'(stall_o), 64'd1);
    chk("b2b no ready T+34", 64'(ready_o), 64'd0);
    for (int c = 0; c < 33; c++) next_cycle();
    @(negedge clk);
    chk("b2b second ready", 64'(ready_o), 64'd1);
    chk("b2b second result", result_o, {32'd2, 32'd2});
    next_cycle();
    start_i = 1'b0;
    @(negedge clk);
    chk("b2b ready drop", 64'(ready_o), 64'd0);
    next_cycle();

    // Synchronous reset in the middle of a division.
    start_i = 1'b1; opdata1_i = 32'd1000; opdata2_i = 32'd3;
    for (int c = 0; c < 5; c++) next_cycle();
    rst = 1'b1;
    @(negedge clk);
    chk("mid-rst stall", 64'(stall_o), 64'd0);
    next_cycle();
    rst = 1'b0; start_i = 1'b0;
    @(negedge clk);
    chk("mid-rst result", result_o, 64'd0);
    chk("mid-rst ready", 64'(ready_o), 64'd0);
    chk("mid-rst stall free", 64'(stall_o), 64'd0);
    next_cycle();
    quiet(40, "mid-rst");

    // Annul that coincides with END does not cancel completion.
    start_i = 1'b1; signed_i = 1'b0; opdata1_i = 32'd200; opdata2_i = 32'd7;
    for (int c = 0; c < 33; c++) next_cycle();
    annul_i = 1'b1;
    @(negedge clk);
    chk("annul-end ready", 64'(ready_o), 64'd1);
    chk("annul-end result", result_o, {32'd4, 32'd28});
    next_cycle();
    annul_i = 1'b0; start_i = 1'b0;
    @(negedge clk);
    chk("annul-end ready drop", 64'(ready_o), 64'd0);
    next_cycle();

    // annul in FREE blocks acceptance.
    start_i = 1'b1; annul_i = 1'b1; opdata1_i = 32'd50; opdata2_i = 32'd5;
    @(negedge clk);
    chk("annul-free stall", 64'(stall_o), 64'd0);
    next_cycle();
    start_i = 1'b0; annul_i = 1'b0;
    quiet(40, "annul-free");
    chk("annul-free result", result_o, {32'd4, 32'd28});

    // Divide by zero.
`ifdef DIV_ZERO_FAST_EN
    run_div(32'd5, 32'd0, 1'b0, 64'd0, 2, 1'b1, "div0 fast");
`else
    run_div(32'd5, 32'd0, 1'b0, 64'd0, 33, 1'b0, "div0 slow");
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
